// File: rtl/mem_responder.sv
// mem_responder: handshaked word-organised RAM slave for the RV32 memory port.
// A request is accepted in IDLE. The block waits WAIT_STATES cycles in BUSY,
// then pulses rsp_valid for one cycle in RESP. It supports byte, half and
// word accesses with lane steering. Misaligned, illegal-size and out-of-range
// accesses are rejected with rsp_err.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we, req_size, req_addr, req_wdata  request fields, sampled at handshake
//   rsp_valid            one-cycle response strobe
//   rsp_rdata, rsp_err   response payload, held until the next response
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, err_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          rerr_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          hs, commit;
  logic          a_we, a_err;
  logic [1:0]    a_size;
  logic [AW+1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    be;
  logic [31:0]   wsh, rword, rsh, rmask;

  function automatic logic access_err(input logic [1:0] sz, input logic [31:0] a);
    logic e;
    e = 1'b0;
    case (sz)
      2'b01:   e = a[0];
      2'b10:   e = |a[1:0];
      2'b11:   e = 1'b1;
      default: e = 1'b0;
    endcase
    if (|a[31:AW+2]) e = 1'b1;
    return e;
  endfunction

  assign req_ready = reset && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;
  assign hs        = req_valid && req_ready;

  // With zero wait states the access commits on the accepting edge, so the
  // live request fields stand in for the not-yet-latched copies.
  always_comb begin
    if (state_q == IDLE) begin
      a_we    = req_we;
      a_size  = req_size;
      a_addr  = req_addr[AW+1:0];
      a_wdata = req_wdata;
      a_err   = access_err(req_size, req_addr);
    end else begin
      a_we    = we_q;
      a_size  = size_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_err   = err_q;
    end
  end

  // Commit happens on the edge that enters RESP.
  assign commit = ((state_q == IDLE) && hs && (WAIT_STATES == 0)) ||
                  ((state_q == BUSY) && (cnt_q == 4'd0));

  always_comb begin
    case (a_size)
      2'b00:   be = 4'b0001 << a_addr[1:0];
      2'b01:   be = 4'b0011 << {a_addr[1], 1'b0};
      default: be = 4'b1111;
    endcase
  end

  assign wsh   = a_wdata << {a_addr[1:0], 3'b000};
  assign rword = mem[a_addr[AW+1:2]];
  assign rsh   = rword >> {a_addr[1:0], 3'b000};

  always_comb begin
    case (a_size)
      2'b00:   rmask = {24'd0, rsh[7:0]};
      2'b01:   rmask = {16'd0, rsh[15:0]};
      default: rmask = rsh;
    endcase
  end

  // RAM has no reset; reset forces IDLE asynchronously so no commit can fire.
  always_ff @(posedge clk) begin
    if (commit && a_we && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[a_addr[AW+1:2]][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d = (WAIT_STATES == 0) ? RESP : BUSY;
        cnt_d   = WS_LOAD;
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
        err_q   <= access_err(req_size, req_addr);
      end
      if (commit) begin
        rdata_q <= (a_we || a_err) ? 32'd0 : rmask;
        rerr_q  <= a_err;
      end
    end
  end

endmodule
